// File: rtl/mips_pkg.sv
// Types and constants shared by the register file, pipeline stages and the
// write-side front end.
package mips_pkg;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } regwr_t;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_WB,
    SEL_FIFO
  } slot_sel_e;

  function automatic logic [31:0] reg_onehot(input logic [ADDR_W-1:0] r);
    return 32'd1 << r;
  endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback bus: pipeline and long-latency request streams in, register-file
// write port and pending-write status out.
interface regfile_writeback_if
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_reg;
  logic [DATA_W-1:0] lu_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [31:0]       pend_mask;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
    input  lu_ready, RegWrite, WriteReg, WriteData, pend_mask, fifo_count
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
    output lu_ready, RegWrite, WriteReg, WriteData, pend_mask, fifo_count
  );
endinterface

// File: rtl/regwr_fifo.sv
// Circular buffer of pending register writes with per-entry live bits,
// squash-by-register, head peek and a onehot mask of live destinations.
module regwr_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  regwr_t                    push_entry_i,
  input  logic                      pop_i,
  input  logic                      squash_i,
  input  logic [ADDR_W-1:0]         squash_reg_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output regwr_t                    head_o,
  output logic                      head_live_o,
  output logic [31:0]               live_mask_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  regwr_t           ent_q [DEPTH];

  // Squash only looks at entries already stored; a same-cycle push overrides
  // it because it is the younger write. Popped slots lose their live bit so
  // the mask covers occupied entries only.
  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (squash_i && (ent_q[i].dst == squash_reg_i)) live_d[i] = 1'b0;
    end
    if (pop_i)  live_d[rd_ptr_q] = 1'b0;
    if (push_i) live_d[wr_ptr_q] = 1'b1;

    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) ent_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    live_mask_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i]) live_mask_o = live_mask_o | reg_onehot(ent_q[i].dst);
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_o      = ent_q[rd_ptr_q];
  assign head_live_o = live_q[rd_ptr_q];
endmodule

// File: rtl/regfile_writeback.sv
// Merges pipeline writeback and buffered long-latency results onto the single
// register-file write port; pipeline has priority.
module regfile_writeback
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  regfile_writeback_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             wb_live;
  logic             lu_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  regwr_t           fifo_head;
  logic             fifo_head_live;
  logic [31:0]      fifo_live_mask;
  slot_sel_e        sel;

  logic   out_we_q, out_we_d;
  regwr_t out_q, out_d;

  assign wb_live = bus.wb_valid && (bus.wb_reg != REG_ZERO);
  // r0 results complete the handshake but are never stored.
  assign lu_push = bus.lu_valid && !fifo_full && (bus.lu_reg != REG_ZERO);

  regwr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clock),
    .rst_i        (reset),
    .push_i       (lu_push),
    .push_entry_i ('{dst: bus.lu_reg, data: bus.lu_data}),
    .pop_i        (fifo_pop),
    .squash_i     (wb_live),
    .squash_reg_i (bus.wb_reg),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (fifo_head),
    .head_live_o  (fifo_head_live),
    .live_mask_o  (fifo_live_mask)
  );

  always_comb begin
    sel      = SEL_IDLE;
    out_we_d = 1'b0;
    out_d    = '0;
    if (wb_live)          sel = SEL_WB;
    else if (!fifo_empty) sel = SEL_FIFO;

    case (sel)
      SEL_WB: begin
        out_we_d = 1'b1;
        out_d    = '{dst: bus.wb_reg, data: bus.wb_data};
      end
      SEL_FIFO: begin
        out_we_d = fifo_head_live;
        out_d    = fifo_head;
      end
      default: begin
        out_we_d = 1'b0;
        out_d    = '0;
      end
    endcase
  end

  assign fifo_pop = (sel == SEL_FIFO);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_we_q <= 1'b0;
      out_q    <= '0;
    end else begin
      out_we_q <= out_we_d;
      out_q    <= out_d;
    end
  end

  assign bus.lu_ready   = !fifo_full;
  assign bus.RegWrite   = out_we_q;
  assign bus.WriteReg   = out_q.dst;
  assign bus.WriteData  = out_q.data;
  assign bus.fifo_count = fifo_count;
  assign bus.pend_mask  = (fifo_live_mask | (out_we_q ? reg_onehot(out_q.dst) : 32'd0))
                          & ~32'd1;
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: expected writes are queued as
// stimulus is issued, a negedge monitor checks every RegWrite pulse.
module tb_regfile_writeback;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_writeback_if #(.DEPTH(DEPTH)) bus ();
  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int     total = 0;
  int     bad   = 0;
  regwr_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 1'b0;
    bus.wb_reg   = '0;
    bus.wb_data  = '0;
    bus.lu_valid = 1'b0;
    bus.lu_reg   = '0;
    bus.lu_data  = '0;
  endtask

  task automatic drive_wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_reg   = r;
    bus.wb_data  = d;
  endtask

  task automatic drive_lu(input logic [4:0] r, input logic [31:0] d);
    bus.lu_valid = 1'b1;
    bus.lu_reg   = r;
    bus.lu_data  = d;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    regwr_t e;
    e.dst  = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int limit);
    for (int c = 0; c < limit && exp_q.size() != 0; c++) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got r%0d=%0h expected no write", bus.WriteReg, bus.WriteData);
      end else begin
        regwr_t e;
        e = exp_q.pop_front();
        check("wr_reg", 64'(bus.WriteReg), 64'(e.dst));
        check("wr_data", 64'(bus.WriteData), 64'(e.data));
      end
    end
  end

  initial begin
    int  lu_idx;
    logic hs;

    idle_inputs();
    reset = 1'b1;
    tick();
    check("rst_regwrite", 64'(bus.RegWrite), 64'd0);
    check("rst_writereg", 64'(bus.WriteReg), 64'd0);
    check("rst_writedata", 64'(bus.WriteData), 64'd0);
    check("rst_count", 64'(bus.fifo_count), 64'd0);
    check("rst_pend", 64'(bus.pend_mask), 64'd0);
    check("rst_ready", 64'(bus.lu_ready), 64'd1);
    reset = 1'b0;
    tick();

    // Single long-latency result, no contention: two-cycle latency.
    expect_wr(5'd5, 32'hAAAA_0001);
    drive_lu(5'd5, 32'hAAAA_0001);
    check("s1_ready", 64'(bus.lu_ready), 64'd1);
    tick();
    idle_inputs();
    check("s1_count", 64'(bus.fifo_count), 64'd1);
    check("s1_nowrite_yet", 64'(bus.RegWrite), 64'd0);
    check("s1_pend_fifo", 64'(bus.pend_mask), 64'h20);
    tick();
    check("s1_regwrite", 64'(bus.RegWrite), 64'd1);
    check("s1_pend_out", 64'(bus.pend_mask), 64'h20);
    tick();
    check("s1_pend_clear", 64'(bus.pend_mask), 64'd0);

    // Pipeline saturation starves the FIFO until it fills.
    for (int i = 1; i <= 8; i++) expect_wr(5'(i), 32'h100 + 32'(i));
    for (int j = 0; j < 6; j++) expect_wr(5'(10 + j), 32'h200 + 32'(j));
    lu_idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive_wb(5'(c + 1), 32'h100 + 32'(c + 1));
      if (lu_idx < 6) drive_lu(5'(10 + lu_idx), 32'h200 + 32'(lu_idx));
      hs = bus.lu_valid && bus.lu_ready;
      tick();
      if (hs) lu_idx++;
    end
    check("s2_accepted_full", 64'(lu_idx), 64'd4);
    check("s2_count_full", 64'(bus.fifo_count), 64'd4);
    check("s2_ready_low", 64'(bus.lu_ready), 64'd0);
    bus.wb_valid = 1'b0;
    for (int c = 0; c < 20 && lu_idx < 6; c++) begin
      drive_lu(5'(10 + lu_idx), 32'h200 + 32'(lu_idx));
      hs = bus.lu_ready;
      tick();
      if (hs) lu_idx++;
    end
    idle_inputs();
    check("s2_accepted_all", 64'(lu_idx), 64'd6);
    drain("s2_drain", 20);
    tick();
    check("s2_count_empty", 64'(bus.fifo_count), 64'd0);

    // Buffered r7 is squashed by a later pipeline write to r7.
    expect_wr(5'd3, 32'h55);
    expect_wr(5'd7, 32'h22);
    drive_wb(5'd3, 32'h55);
    drive_lu(5'd7, 32'h11);
    tick();
    idle_inputs();
    check("s3_count", 64'(bus.fifo_count), 64'd1);
    check("s3_pend_both", 64'(bus.pend_mask), 64'h88);
    drive_wb(5'd7, 32'h22);
    tick();
    idle_inputs();
    check("s3_count_squashed", 64'(bus.fifo_count), 64'd1);
    check("s3_pend_out7", 64'(bus.pend_mask), 64'h80);
    tick();
    check("s3_squashed_slot", 64'(bus.RegWrite), 64'd0);
    check("s3_count_after", 64'(bus.fifo_count), 64'd0);
    check("s3_pend_after", 64'(bus.pend_mask), 64'd0);

    // Same-cycle push and pipeline write to r9: push is younger, not squashed.
    expect_wr(5'd9, 32'h44);
    expect_wr(5'd9, 32'h33);
    drive_wb(5'd9, 32'h44);
    drive_lu(5'd9, 32'h33);
    tick();
    idle_inputs();
    check("s4_count", 64'(bus.fifo_count), 64'd1);
    check("s4_pend", 64'(bus.pend_mask), 64'h200);
    tick();
    check("s4_count_after", 64'(bus.fifo_count), 64'd0);
    check("s4_pend_out", 64'(bus.pend_mask), 64'h200);
    tick();
    check("s4_pend_clear", 64'(bus.pend_mask), 64'd0);

    // r0 on both streams: nothing written or stored; head drains in that slot.
    expect_wr(5'd2, 32'h66);
    expect_wr(5'd11, 32'h77);
    drive_wb(5'd2, 32'h66);
    drive_lu(5'd11, 32'h77);
    tick();
    check("s5_count", 64'(bus.fifo_count), 64'd1);
    drive_wb(5'd0, 32'hDEAD);
    drive_lu(5'd0, 32'hBEEF);
    check("s5_ready_r0", 64'(bus.lu_ready), 64'd1);
    tick();
    check("s5_count_r0", 64'(bus.fifo_count), 64'd0);
    check("s5_head_drained", 64'(bus.WriteReg), 64'd11);
    tick();
    idle_inputs();
    check("s5_no_r0_write", 64'(bus.RegWrite), 64'd0);
    check("s5_count_still0", 64'(bus.fifo_count), 64'd0);
    check("s5_pend_zero", 64'(bus.pend_mask), 64'd0);

    // Reset with three entries buffered and a write in the output stage.
    for (int i = 1; i <= 3; i++) begin
      expect_wr(5'(i), 32'hA0 + 32'(i));
      drive_wb(5'(i), 32'hA0 + 32'(i));
      drive_lu(5'(19 + i), 32'hB0 + 32'(i));
      tick();
    end
    idle_inputs();
    check("s6_count_pre", 64'(bus.fifo_count), 64'd3);
    check("s6_regwrite_pre", 64'(bus.RegWrite), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s6_regwrite", 64'(bus.RegWrite), 64'd0);
    check("s6_writereg", 64'(bus.WriteReg), 64'd0);
    check("s6_writedata", 64'(bus.WriteData), 64'd0);
    check("s6_count", 64'(bus.fifo_count), 64'd0);
    check("s6_pend", 64'(bus.pend_mask), 64'd0);
    check("s6_ready", 64'(bus.lu_ready), 64'd1);
    for (int c = 0; c < 6; c++) tick();
    check("s6_count_later", 64'(bus.fifo_count), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
